control_sequencer: RTL and testbench

SAP-1 controller-sequencer: the initiator that drives the program counter's `inc` and `pc_out_en` lines, plus every other load and output-enable strobe on the shared 8-bit bus. A one-hot six-state ring (T1–T6) sequences a three-state fetch, then up to three execute states decoded from the instruction register's opcode nibble. It sits between the instruction register and all datapath blocks: program counter, MAR, RAM, A, B, ALU and output register.

---
 rtl/control_sequencer_if.sv | 32 +++
 rtl/control_sequencer.sv | 117 +++++++++++
 tb/tb_control_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - SAP-1 sequencer control bus: opcode in, ring state and strobes out
interface control_sequencer_if;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       inc;
  logic       pc_out_en;
  logic       mar_load;
  logic       ram_out_en;
  logic       ir_load;
  logic       ir_out_en;
  logic       a_load;
  logic       a_out_en;
  logic       b_load;
  logic       alu_sub;
  logic       alu_out_en;
  logic       out_load;
  logic       halt;

  // Sequencer side: reads the opcode, drives ring state and every strobe
  modport master (
    input  opcode,
    output t_state, inc, pc_out_en, mar_load, ram_out_en, ir_load, ir_out_en,
           a_load, a_out_en, b_load, alu_sub, alu_out_en, out_load, halt
  );

  // Datapath side: supplies the opcode, consumes ring state and strobes
  modport slave (
    output opcode,
    input  t_state, inc, pc_out_en, mar_load, ram_out_en, ir_load, ir_out_en,
           a_load, a_out_en, b_load, alu_sub, alu_out_en, out_load, halt
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - SAP-1 one-hot T1..T6 ring with fetch/execute strobe decode and HLT freeze
module control_sequencer (
  input  logic                 clk,
  input  logic                 clr,
  control_sequencer_if.master  bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  t_state_e state_q, state_d;
  logic     halt_q, halt_d;

  // Next ring position; HLT seen in T4 latches halt instead of advancing, and halt freezes the ring
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      if (state_q == T4 && bus.opcode == OP_HLT) begin
        halt_d = 1'b1;
      end else begin
        case (state_q)
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          T4:      state_d = T5;
          T5:      state_d = T6;
          T6:      state_d = T1;
          default: state_d = T1;
        endcase
      end
    end
  end

  // State and halt flops; clr wins over the halt freeze and any partial instruction
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.t_state = state_q;
  assign bus.halt    = halt_q;

  // Strobe decode from ring state and opcode; clr or halt silences everything
  always_comb begin
    bus.inc        = 1'b0;
    bus.pc_out_en  = 1'b0;
    bus.mar_load   = 1'b0;
    bus.ram_out_en = 1'b0;
    bus.ir_load    = 1'b0;
    bus.ir_out_en  = 1'b0;
    bus.a_load     = 1'b0;
    bus.a_out_en   = 1'b0;
    bus.b_load     = 1'b0;
    bus.alu_sub    = 1'b0;
    bus.alu_out_en = 1'b0;
    bus.out_load   = 1'b0;
    if (!clr && !halt_q) begin
      case (state_q)
        T1: begin
          bus.pc_out_en = 1'b1;
          bus.mar_load  = 1'b1;
        end
        T2: bus.inc = 1'b1;
        T3: begin
          bus.ram_out_en = 1'b1;
          bus.ir_load    = 1'b1;
        end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.ir_out_en = 1'b1;
            bus.mar_load  = 1'b1;
          end else if (bus.opcode == OP_OUT) begin
            bus.a_out_en = 1'b1;
            bus.out_load = 1'b1;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            bus.ram_out_en = 1'b1;
            bus.a_load     = 1'b1;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.ram_out_en = 1'b1;
            bus.b_load     = 1'b1;
            bus.alu_sub    = (bus.opcode == OP_SUB);
          end
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            bus.alu_out_en = 1'b1;
            bus.a_load     = 1'b1;
            bus.alu_sub    = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed plus randomized check of control_sequencer against an instruction-table model
module tb_control_sequencer;

  logic clk;
  logic clr;
  int   n_tests;
  int   n_fail;
  int   m_step;
  bit   m_halt;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_INC  = 11;
  localparam int S_PC   = 10;
  localparam int S_MAR  = 9;
  localparam int S_RAMO = 8;
  localparam int S_IRL  = 7;
  localparam int S_IRO  = 6;
  localparam int S_AL   = 5;
  localparam int S_AO   = 4;
  localparam int S_BL   = 3;
  localparam int S_SUB  = 2;
  localparam int S_ALUO = 1;
  localparam int S_OUTL = 0;

  function automatic logic [11:0] actual_strobes();
    return {bus.inc, bus.pc_out_en, bus.mar_load, bus.ram_out_en, bus.ir_load, bus.ir_out_en,
            bus.a_load, bus.a_out_en, bus.b_load, bus.alu_sub, bus.alu_out_en, bus.out_load};
  endfunction

  // Micro-op table: which strobes each step (0=T1..5=T6) of each instruction asserts
  function automatic logic [11:0] expected_strobes(input int step, input logic [3:0] op,
                                                   input bit halted, input logic rst);
    logic [11:0] e;
    e = '0;
    if (rst || halted) return e;
    case (step)
      0: begin e[S_PC] = 1'b1; e[S_MAR] = 1'b1; end
      1: e[S_INC] = 1'b1;
      2: begin e[S_RAMO] = 1'b1; e[S_IRL] = 1'b1; end
      3: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin e[S_IRO] = 1'b1; e[S_MAR] = 1'b1; end
        if (op == 4'hE) begin e[S_AO] = 1'b1; e[S_OUTL] = 1'b1; end
      end
      4: begin
        if (op == 4'h0) begin e[S_RAMO] = 1'b1; e[S_AL] = 1'b1; end
        if (op == 4'h1 || op == 4'h2) begin e[S_RAMO] = 1'b1; e[S_BL] = 1'b1; e[S_SUB] = (op == 4'h2); end
      end
      5: begin
        if (op == 4'h1 || op == 4'h2) begin e[S_ALUO] = 1'b1; e[S_AL] = 1'b1; e[S_SUB] = (op == 4'h2); end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string tag);
    logic [5:0]  exp_t;
    logic [11:0] exp_s;
    logic [11:0] act_s;
    int          n_oe;
    exp_t = 6'(1 << m_step);
    exp_s = expected_strobes(m_step, bus.opcode, m_halt, clr);
    act_s = actual_strobes();
    n_oe  = $countones({bus.pc_out_en, bus.ram_out_en, bus.ir_out_en, bus.a_out_en, bus.alu_out_en});
    n_tests++;
    assert (bus.t_state === exp_t) else begin
      n_fail++;
      $error("FAIL %s t_state got %b expected %b", tag, bus.t_state, exp_t);
    end
    n_tests++;
    assert (bus.halt === m_halt) else begin
      n_fail++;
      $error("FAIL %s halt got %b expected %b", tag, bus.halt, m_halt);
    end
    n_tests++;
    assert (act_s === exp_s) else begin
      n_fail++;
      $error("FAIL %s strobes got %b expected %b", tag, act_s, exp_s);
    end
    n_tests++;
    assert (n_oe <= 1) else begin
      n_fail++;
      $error("FAIL %s bus_invariant got %0d drivers expected at most 1", tag, n_oe);
    end
  endtask

  // Check the current cycle, advance the model by one clock, then take the edge
  task automatic cyc(input string tag);
    #1;
    check(tag);
    if (clr) begin
      m_step = 0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_step == 3 && bus.opcode == 4'hF) m_halt = 1'b1;
      else m_step = (m_step + 1) % 6;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    logic [3:0] pick [7];
    n_tests    = 0;
    n_fail     = 0;
    m_step     = 0;
    m_halt     = 1'b0;
    pick       = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h5, 4'h9};
    clr        = 1'b1;
    bus.opcode = 4'h0;

    @(posedge clk);
    #1;
    cyc("reset");
    clr = 1'b0;

    run(6, "lda");
    bus.opcode = 4'h1;
    run(6, "add");
    bus.opcode = 4'h2;
    run(6, "sub");
    bus.opcode = 4'hE;
    run(6, "out");
    bus.opcode = 4'h5;
    run(6, "undef");

    bus.opcode = 4'hF;
    run(4, "hlt_enter");
    run(20, "hlt_frozen");
    clr = 1'b1;
    cyc("hlt_clr");
    clr = 1'b0;

    bus.opcode = 4'h1;
    run(4, "add_pre");
    clr = 1'b1;
    cyc("add_t5_clr");
    clr = 1'b0;
    run(6, "after_clr");

    for (int i = 0; i < 600; i++) begin
      if (m_step == 0 && !m_halt) bus.opcode = ($urandom_range(0, 3) == 0) ? 4'($urandom) : pick[$urandom_range(0, 6)];
      clr = ($urandom_range(0, 24) == 0);
      cyc("random");
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
